// File: rtl/vend_pkg.sv
// Shared vending definitions: money/slot sizing, denominations and dispense FSM encoding.
package vend_pkg;

    localparam int MONEY_W = 8;
    localparam int SLOT_N  = 16;
    localparam int SLOT_W  = $clog2(SLOT_N);
    localparam int AMT_W   = MONEY_W + 1;
    localparam int TMR_W   = 16;

    // Denomination value equals its coin_ej strobe bit pattern.
    localparam logic [2:0] DEN4 = 3'd4;
    localparam logic [2:0] DEN2 = 3'd2;
    localparam logic [2:0] DEN1 = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOTOR = 3'd1,
        ST_SEL   = 3'd2,
        ST_EJECT = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } vend_state_e;

    function automatic logic [2:0] pick_den(input logic [AMT_W-1:0] amt);
        if (amt >= AMT_W'(DEN4)) return DEN4;
        if (amt >= AMT_W'(DEN2)) return DEN2;
        return DEN1;
    endfunction

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Request/actuator bundle between the vending FSM side (master) and the dispense controller (slave).
interface vend_dispense_ctrl_if;
    import vend_pkg::*;

    logic               start;
    logic [SLOT_W-1:0]  it_slot;
    logic [MONEY_W-1:0] price;
    logic [MONEY_W-1:0] change;
    logic               drop_sns;
    logic [SLOT_N-1:0]  motor_en;
    logic [2:0]         coin_ej;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, it_slot, price, change, drop_sns,
        input  motor_en, coin_ej, busy, done, err
    );

    modport slave (
        input  start, it_slot, price, change, drop_sns,
        output motor_en, coin_ej, busy, done, err
    );

endinterface

// File: rtl/vend_cycle_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module vend_cycle_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         res,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (res) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Motor-until-drop then greedy 4/2/1 coin refund sequencer. Optional drop timeout: VEND_TIMEOUT_EN.
// state | meaning
// IDLE  | waiting for start          MOTOR | slot motor on, waiting for drop
// SEL   | pick next coin or finish   EJECT | one ejector strobe high
// GAP   | quiet time after strobe    DONE  | one-cycle completion (err if refund)
module vend_dispense_ctrl
    import vend_pkg::*;
#(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2,
    parameter int DROP_TMO  = 1000
) (
    input  logic clk,
    input  logic res,
    vend_dispense_ctrl_if.slave bus
);

    vend_state_e        state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [MONEY_W-1:0] price_q, price_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic [2:0]         den_q, den_d;
    logic               refund_q, refund_d;
    logic               drop_q;
    logic [SLOT_N-1:0]  motor_en_q, motor_en_d;
    logic [2:0]         coin_ej_q, coin_ej_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;

    vend_cycle_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .res        (res),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        price_d  = price_q;
        change_d = change_q;
        amt_d    = amt_q;
        den_d    = den_q;
        refund_d = refund_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            ST_IDLE: if (bus.start) begin
                slot_d   = bus.it_slot;
                price_d  = bus.price;
                change_d = bus.change;
                amt_d    = '0;
                refund_d = 1'b0;
`ifdef VEND_TIMEOUT_EN
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(DROP_TMO - 1);
`endif
                state_d  = ST_MOTOR;
            end
            // A drop seen on the timeout edge takes priority over the refund.
            ST_MOTOR: if (drop_q) begin
                amt_d   = AMT_W'(change_q);
                state_d = ST_SEL;
            end
`ifdef VEND_TIMEOUT_EN
            else if (tmr_zero) begin
                amt_d    = AMT_W'(price_q) + AMT_W'(change_q);
                refund_d = 1'b1;
                state_d  = ST_SEL;
            end
`endif
            ST_SEL: begin
                if (amt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    den_d    = pick_den(amt_q);
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PULSE_CYC - 1);
                    state_d  = ST_EJECT;
                end
            end
            ST_EJECT: if (tmr_zero) begin
                amt_d    = amt_q - AMT_W'(den_q);
                tmr_load = 1'b1;
                tmr_val  = TMR_W'(GAP_CYC - 1);
                state_d  = ST_GAP;
            end
            ST_GAP:  if (tmr_zero) state_d = ST_SEL;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        motor_en_d = (state_d == ST_MOTOR) ? (SLOT_N'(1) << slot_d) : '0;
        coin_ej_d  = (state_d == ST_EJECT) ? den_d : 3'b000;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        err_d      = done_d & refund_d;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q    <= ST_IDLE;
            slot_q     <= '0;
            price_q    <= '0;
            change_q   <= '0;
            amt_q      <= '0;
            den_q      <= '0;
            refund_q   <= 1'b0;
            drop_q     <= 1'b0;
            motor_en_q <= '0;
            coin_ej_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            price_q    <= price_d;
            change_q   <= change_d;
            amt_q      <= amt_d;
            den_q      <= den_d;
            refund_q   <= refund_d;
            drop_q     <= bus.drop_sns & (state_q == ST_MOTOR);
            motor_en_q <= motor_en_d;
            coin_ej_q  <= coin_ej_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifndef VEND_TIMEOUT_EN
    logic unused_cfg;
    assign unused_cfg = ^{price_q, (DROP_TMO > 0)};
`endif

    assign bus.motor_en = motor_en_q;
    assign bus.coin_ej  = coin_ej_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: vector table, reset corner case, randomized vends vs a timing/coin model.
module tb_vend_dispense_ctrl;
    import vend_pkg::*;

    localparam int PULSE = 4;
    localparam int GAP   = 2;
`ifdef VEND_TIMEOUT_EN
    localparam int TMO    = 20;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 1000;
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int COIN_CYC = 1 + PULSE + GAP;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    vend_dispense_ctrl_if bus();

    vend_dispense_ctrl #(.PULSE_CYC(PULSE), .GAP_CYC(GAP), .DROP_TMO(TMO)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Model: cycle indices count from the cycle that begins at the accept edge (c=0).
    int exp_coins[$];
    int exp_motor, exp_done;
    bit exp_err;

    task automatic build_model(input int price, input int change, input int drop_dly);
        int  exit_c, refund;
        bit  timeout;
        exit_c  = (drop_dly >= 0) ? drop_dly + 2 : 1 << 30;
        timeout = TMO_EN && (exit_c > TMO);
        if (timeout) exit_c = TMO;
        refund = timeout ? price + change : change;
        exp_coins.delete();
        repeat (refund / 4)       exp_coins.push_back(4);
        repeat ((refund % 4) / 2) exp_coins.push_back(2);
        repeat (refund % 2)       exp_coins.push_back(1);
        exp_motor = exit_c;
        exp_done  = exit_c + 1 + exp_coins.size() * COIN_CYC;
        exp_err   = timeout;
    endtask

    task automatic run_vend(input string tag, input int slot, input int price, input int change,
                            input int drop_dly, input bit poke,
                            output int o_motor, output int o_done, output int o_ncoins, output int o_err);
        int  c, budget, motor_cyc, cur_len, low_run;
        int  len_bad, gap_bad, hot_bad, motor_bad, err_bad, busy_bad;
        int  done_c, busy_at_done, err_at_done;
        bit  seen_done, poked;
        int  got[$];
        logic [SLOT_N-1:0] onehot;

        build_model(price, change, drop_dly);
        onehot = SLOT_N'(1) << slot;

        bus.start    = 1'b1;
        bus.it_slot  = SLOT_W'(slot);
        bus.price    = MONEY_W'(price);
        bus.change   = MONEY_W'(change);
        bus.drop_sns = 1'b0;
        tick;
        bus.start   = 1'b0;
        bus.it_slot = SLOT_W'($urandom);
        bus.price   = MONEY_W'($urandom);
        bus.change  = MONEY_W'($urandom);

        c = 0; motor_cyc = 0; cur_len = 0; low_run = GAP + 1;
        len_bad = 0; gap_bad = 0; hot_bad = 0; motor_bad = 0; err_bad = 0; busy_bad = 0;
        done_c = -1; busy_at_done = 0; err_at_done = 0;
        seen_done = 1'b0; poked = 1'b0;
        budget = exp_done + 40;

        while (!seen_done && c <= budget) begin
            if (bus.motor_en == onehot) begin
                if (motor_cyc == c) motor_cyc++;
                else motor_bad++;
            end else if (bus.motor_en != '0) begin
                motor_bad++;
            end
            if (bus.coin_ej != 3'b000) begin
                if (!$onehot(bus.coin_ej)) hot_bad++;
                if (cur_len == 0) begin
                    got.push_back(int'(bus.coin_ej));
                    if (low_run < GAP + 1) gap_bad++;
                end
                cur_len++;
                low_run = 0;
            end else begin
                if (cur_len != 0 && cur_len != PULSE) len_bad++;
                cur_len = 0;
                low_run++;
            end
            if (!bus.busy) busy_bad++;
            if (bus.done) begin
                seen_done    = 1'b1;
                done_c       = c;
                busy_at_done = int'(bus.busy);
                err_at_done  = int'(bus.err);
            end else if (bus.err) begin
                err_bad++;
            end

            bus.drop_sns = (drop_dly >= 0 && c >= drop_dly);
            if (poke && !poked && cur_len == 1) begin
                bus.start   = 1'b1;
                bus.it_slot = SLOT_W'(slot ^ 1);
                bus.change  = 8'd3;
                poked = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (!seen_done) begin
                tick;
                c++;
            end
        end
        bus.start    = 1'b0;
        bus.drop_sns = 1'b0;

        check({tag, " done_latency"}, done_c, exp_done);
        check({tag, " motor_cycles"}, motor_cyc, exp_motor);
        check({tag, " motor_stray"}, motor_bad, 0);
        check({tag, " coin_count"}, got.size(), exp_coins.size());
        foreach (exp_coins[i])
            check($sformatf("%s coin%0d", tag, i), (i < got.size()) ? got[i] : -1, exp_coins[i]);
        check({tag, " strobe_len"}, len_bad, 0);
        check({tag, " strobe_gap"}, gap_bad, 0);
        check({tag, " strobe_onehot"}, hot_bad, 0);
        check({tag, " err_at_done"}, err_at_done, int'(exp_err));
        check({tag, " err_stray"}, err_bad, 0);
        check({tag, " busy_held"}, busy_bad + (busy_at_done == 0 ? 1 : 0), 0);

        tick;
        check({tag, " busy_release"}, bus.busy, 0);
        check({tag, " done_pulse"}, bus.done, 0);
        tick;
        check({tag, " still_idle"}, bus.busy | bus.motor_en != '0, 0);

        o_motor  = motor_cyc;
        o_done   = done_c;
        o_ncoins = got.size();
        o_err    = err_at_done;
    endtask

    typedef struct {
        int slot, price, change, drop_dly;
        bit poke;
        int exp_motor, exp_done, exp_ncoins, exp_err;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish before 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int om, od, on, oe, hit;

        // slot, price, change, drop_dly, poke | motor, done, coins, err
        vecs.push_back('{2,   5,   0, 3, 1'b0, 5,   6,  0, 0});
        vecs.push_back('{0,   9,   7, 1, 1'b0, 3,  25,  3, 0});
        vecs.push_back('{15, 100, 255, 0, 1'b1, 2, 458, 65, 0});
        vecs.push_back('{7,   1,   2, 6, 1'b1, 8,  16,  1, 0});
        vecs.push_back('{9,   0,   6, 2, 1'b0, 4,  19,  2, 0});
        vecs.push_back('{3,  50,   1, 0, 1'b0, 2,  10,  1, 0});
`ifdef VEND_TIMEOUT_EN
        vecs.push_back('{4,   3,   2, -1, 1'b0, 20, 35, 2, 1});
        vecs.push_back('{6,   3,   2, 18, 1'b0, 20, 28, 1, 0});
        vecs.push_back('{6,   3,   2, 19, 1'b0, 20, 35, 2, 1});
`endif

        res = 1'b1;
        bus.start = 1'b0; bus.it_slot = '0; bus.price = '0; bus.change = '0; bus.drop_sns = 1'b0;
        tick; tick;
        check("reset motor_en", bus.motor_en, 0);
        check("reset coin_ej", bus.coin_ej, 0);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset err", bus.err, 0);
        res = 1'b0;
        tick;

        foreach (vecs[i]) begin
            run_vend($sformatf("vec%0d", i), vecs[i].slot, vecs[i].price, vecs[i].change,
                     vecs[i].drop_dly, vecs[i].poke, om, od, on, oe);
            check($sformatf("vec%0d tbl_motor", i), om, vecs[i].exp_motor);
            check($sformatf("vec%0d tbl_done", i), od, vecs[i].exp_done);
            check($sformatf("vec%0d tbl_coins", i), on, vecs[i].exp_ncoins);
            check($sformatf("vec%0d tbl_err", i), oe, vecs[i].exp_err);
        end

        // Reset in the middle of a strobe, then a fresh vend.
        bus.start = 1'b1; bus.it_slot = 4'd4; bus.price = 8'd0; bus.change = 8'd7;
        tick;
        bus.start = 1'b0;
        bus.drop_sns = 1'b1;
        hit = 0;
        for (int k = 0; k < 30 && hit == 0; k++) begin
            if (bus.coin_ej != 3'b000) hit = 1;
            else tick;
        end
        check("rst_mid reached_eject", hit, 1);
        tick;
        res = 1'b1;
        tick;
        res = 1'b0;
        bus.drop_sns = 1'b0;
        check("rst_mid motor_en", bus.motor_en, 0);
        check("rst_mid coin_ej", bus.coin_ej, 0);
        check("rst_mid busy", bus.busy, 0);
        check("rst_mid done_err", {bus.done, bus.err}, 0);
        tick;
        check("rst_mid stays_idle", bus.busy, 0);
        run_vend("post_rst", 5, 0, 1, 2, 1'b0, om, od, on, oe);

        for (int r = 0; r < 25; r++) begin
            int dd, ch;
            ch = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
            if (TMO_EN && $urandom_range(0, 4) == 0) dd = -1;
            else dd = TMO_EN ? $urandom_range(0, 25) : $urandom_range(0, 12);
            run_vend($sformatf("rnd%0d", r), $urandom_range(0, 15), $urandom_range(0, 255), ch,
                     dd, 1'($urandom_range(0, 1)), om, od, on, oe);
            repeat ($urandom_range(0, 2)) tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
